pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipeline_hazard_ctrl_hazard_compare.sv | 35 +++
 rtl/pipeline_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and widths for the pipeline hazard controller and the
// helpers built around it (hazard_compare, forwarding unit).
//   state_e : sequencer state (RUN / MEMWAIT / FLUSH)
//   REG_W   : register-index width of the ARM register file
//   PERF_W  : width of the optional performance counters
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_W  = 4;
    localparam int PERF_W = 16;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        FLUSH   = 2'd2
    } state_e;

endpackage : pipe_ctrl_pkg

// File: rtl/pipeline_hazard_ctrl_hazard_compare.sv
// ---------------------------------------------------------------------------
// hazard_compare
// Combinational load-use detector. Flags when the instruction in decode
// reads a register that the load sitting in ID/EX is about to write.
// Kept separate so the forwarding unit can reuse the same compare.
// Ports:
//   i_id_rn / i_id_rm           : decode source register indices
//   i_id_rn_used / i_id_rm_used : source actually read by the instruction
//   i_ex_load                   : ID/EX holds a load
//   i_ex_rf                     : ID/EX writes the register file
//   i_ex_rd                     : ID/EX destination register
//   o_hazard                    : load-use hazard present
// ---------------------------------------------------------------------------
module hazard_compare
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] i_id_rn,
    input  logic [REG_W-1:0] i_id_rm,
    input  logic             i_id_rn_used,
    input  logic             i_id_rm_used,
    input  logic             i_ex_load,
    input  logic             i_ex_rf,
    input  logic [REG_W-1:0] i_ex_rd,
    output logic             o_hazard
);

    logic w_rn_hit;
    logic w_rm_hit;

    // An unused source field may hold garbage, so it only counts when used.
    assign w_rn_hit = i_id_rn_used & (i_id_rn == i_ex_rd);
    assign w_rm_hit = i_id_rm_used & (i_id_rm == i_ex_rd);
    assign o_hazard = i_ex_load & i_ex_rf & (w_rn_hit | w_rm_hit);

endmodule : hazard_compare

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage ARM pipeline.
//   - load-use stall against ID/EX (one-cycle bubble)
//   - wrong-path squash after a taken branch (BR_PENALTY cycles)
//   - full freeze while multi-cycle data memory is busy, with timeout
// Optional build macro: HAZARD_PERF_EN adds Stall_Cycles / Flush_Events.
//
// Ports:
//   CLK, CLR (async active-low reset)
//   ID_Rn, ID_Rm, ID_Rn_Used, ID_Rm_Used : decode sources
//   EX_Load, EX_rf, EX_Rd                : ID/EX destination info
//   Branch_Taken                         : branch resolved taken
//   Mem_Req, Mem_Ready                   : data-memory handshake
//   PC_Enable, IFID_Enable, IFID_Clear, IDEX_Clear, EXMEM_Enable : controls
//   Mem_Error                            : sticky memory timeout flag
//   Dbg_State                            : current sequencer state
//   Stall_Cycles, Flush_Events           : perf counters (HAZARD_PERF_EN)
//
// Memory handshake: Mem_Req marks the cycle the MEM stage starts an access;
// the access completes in the cycle Mem_Ready is high. If Mem_Ready is high
// together with Mem_Req the access is single-cycle and nothing stalls.
// Outputs are Mealy: combinational from state and current inputs.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int BR_PENALTY  = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
)(
    input  logic             CLK,
    input  logic             CLR,
    input  logic [REG_W-1:0] ID_Rn,
    input  logic [REG_W-1:0] ID_Rm,
    input  logic             ID_Rn_Used,
    input  logic             ID_Rm_Used,
    input  logic             EX_Load,
    input  logic             EX_rf,
    input  logic [REG_W-1:0] EX_Rd,
    input  logic             Branch_Taken,
    input  logic             Mem_Req,
    input  logic             Mem_Ready,
    output logic             PC_Enable,
    output logic             IFID_Enable,
    output logic             IFID_Clear,
    output logic             IDEX_Clear,
    output logic             EXMEM_Enable,
    output logic             Mem_Error,
    output logic [1:0]       Dbg_State
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] Stall_Cycles,
    output logic [PERF_W-1:0] Flush_Events
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(BR_PENALTY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_err;

    state_e           w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_set_err;
    logic             w_lu;
    logic             w_mem_stall;
    logic             w_flush_evt;
    logic             w_pc_en;
    logic             w_ifid_en;
    logic             w_ifid_clr;
    logic             w_idex_clr;
    logic             w_exmem_en;

    hazard_compare u_hazard_compare (
        .i_id_rn      (ID_Rn),
        .i_id_rm      (ID_Rm),
        .i_id_rn_used (ID_Rn_Used),
        .i_id_rm_used (ID_Rm_Used),
        .i_ex_load    (EX_Load),
        .i_ex_rf      (EX_rf),
        .i_ex_rd      (EX_Rd),
        .o_hazard     (w_lu)
    );

    assign w_mem_stall = Mem_Req & ~Mem_Ready;
    // Counter saturates rather than wrapping.
    assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

    // -----------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_set_err) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------
    // Next state and Mealy outputs
    // -----------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_set_err    = 1'b0;
        w_flush_evt  = 1'b0;
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
        w_ifid_clr   = 1'b0;
        w_idex_clr   = 1'b0;
        w_exmem_en   = 1'b1;

        case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    // Memory stall outranks branch and load-use.
                    w_pc_en      = 1'b0;
                    w_ifid_en    = 1'b0;
                    w_exmem_en   = 1'b0;
                    w_next_cnt   = CNT_ONE;
                    w_next_state = MEMWAIT;
                end else if (Branch_Taken) begin
                    w_ifid_clr  = 1'b1;
                    w_idex_clr  = 1'b1;
                    w_next_cnt  = CNT_ONE;
                    w_flush_evt = 1'b1;
                    // A one-cycle penalty is fully covered by this cycle.
                    if (BR_PENALTY != 1) begin
                        w_next_state = FLUSH;
                    end
                end else if (w_lu) begin
                    // Hold PC and IF/ID, inject one bubble into ID/EX; the
                    // load moves on next cycle so the hazard clears itself.
                    w_pc_en    = 1'b0;
                    w_ifid_en  = 1'b0;
                    w_idex_clr = 1'b1;
                end
            end

            MEMWAIT: begin
                // Whole pipeline frozen; branch and load-use are ignored
                // here and re-evaluated once back in RUN.
                w_pc_en    = 1'b0;
                w_ifid_en  = 1'b0;
                w_exmem_en = 1'b0;
                if (Mem_Ready) begin
                    w_next_state = RUN;
                    w_next_cnt   = '0;
                end else if (r_cnt == TIMEOUT_C) begin
                    w_set_err    = 1'b1;
                    w_next_state = RUN;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = w_cnt_inc;
                end
            end

            FLUSH: begin
                w_ifid_clr = 1'b1;
                w_idex_clr = 1'b1;
                if (w_mem_stall) begin
                    // Remaining flush cycles are dropped: the wrong-path
                    // instructions have already been cleared.
                    w_next_state = MEMWAIT;
                    w_next_cnt   = CNT_ONE;
                end else if (r_cnt == FLUSH_LAST) begin
                    w_next_state = RUN;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = w_cnt_inc;
                end
            end

            default: begin
                w_next_state = RUN;
                w_next_cnt   = '0;
            end
        endcase
    end

    // While CLR is low the outputs are forced to their reset values without
    // waiting for a clock edge.
    assign PC_Enable    = CLR & w_pc_en;
    assign IFID_Enable  = CLR & w_ifid_en;
    assign EXMEM_Enable = CLR & w_exmem_en;
    assign IFID_Clear   = ~CLR | w_ifid_clr;
    assign IDEX_Clear   = ~CLR | w_idex_clr;
    assign Mem_Error    = r_mem_err;
    assign Dbg_State    = r_state;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_stall_cycles;
    logic [PERF_W-1:0] r_flush_events;

    // The flops only count while CLR is high, so the ungated PC enable is
    // the right stall qualifier.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!w_pc_en && (r_stall_cycles != {PERF_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + PERF_W'(1);
            end
            if (w_flush_evt && (r_flush_events != {PERF_W{1'b1}})) begin
                r_flush_events <= r_flush_events + PERF_W'(1);
            end
        end
    end

    assign Stall_Cycles = r_stall_cycles;
    assign Flush_Events = r_flush_events;
`endif

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl. Two instances share the inputs:
// u_dut with BR_PENALTY=2 and u_dut1 with BR_PENALTY=1. Output vectors are
// packed as {PC_Enable, IFID_Enable, IFID_Clear, IDEX_Clear, EXMEM_Enable,
// Mem_Error}. Inputs change 1 ns after the rising edge, checks at the
// falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam logic [5:0] V_RST   = 6'b001100;
    localparam logic [5:0] V_RUN   = 6'b110010;
    localparam logic [5:0] V_RUNE  = 6'b110011;
    localparam logic [5:0] V_FRZ   = 6'b000000;
    localparam logic [5:0] V_BR    = 6'b111110;
    localparam logic [5:0] V_BRE   = 6'b111111;
    localparam logic [5:0] V_LU    = 6'b000110;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_MW    = 2'd1;
    localparam logic [1:0] S_FL    = 2'd2;

    logic       CLK;
    logic       CLR;
    logic [3:0] ID_Rn, ID_Rm, EX_Rd;
    logic       ID_Rn_Used, ID_Rm_Used, EX_Load, EX_rf;
    logic       Branch_Taken, Mem_Req, Mem_Ready;

    logic       pc0, ifen0, ifclr0, idclr0, exen0, err0;
    logic       pc1, ifen1, ifclr1, idclr1, exen1, err1;
    logic [1:0] st0, st1;
    logic [5:0] o0, o1;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall0, flush0, stall1, flush1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] exp_q[$];

    assign o0 = {pc0, ifen0, ifclr0, idclr0, exen0, err0};
    assign o1 = {pc1, ifen1, ifclr1, idclr1, exen1, err1};

    pipeline_hazard_ctrl #(.BR_PENALTY(2), .MEM_TIMEOUT(15), .CNT_W(4)) u_dut (
        .CLK(CLK), .CLR(CLR),
        .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rn_Used(ID_Rn_Used), .ID_Rm_Used(ID_Rm_Used),
        .EX_Load(EX_Load), .EX_rf(EX_rf), .EX_Rd(EX_Rd),
        .Branch_Taken(Branch_Taken), .Mem_Req(Mem_Req), .Mem_Ready(Mem_Ready),
        .PC_Enable(pc0), .IFID_Enable(ifen0), .IFID_Clear(ifclr0),
        .IDEX_Clear(idclr0), .EXMEM_Enable(exen0), .Mem_Error(err0),
        .Dbg_State(st0)
`ifdef HAZARD_PERF_EN
        , .Stall_Cycles(stall0), .Flush_Events(flush0)
`endif
    );

    pipeline_hazard_ctrl #(.BR_PENALTY(1), .MEM_TIMEOUT(15), .CNT_W(4)) u_dut1 (
        .CLK(CLK), .CLR(CLR),
        .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rn_Used(ID_Rn_Used), .ID_Rm_Used(ID_Rm_Used),
        .EX_Load(EX_Load), .EX_rf(EX_rf), .EX_Rd(EX_Rd),
        .Branch_Taken(Branch_Taken), .Mem_Req(Mem_Req), .Mem_Ready(Mem_Ready),
        .PC_Enable(pc1), .IFID_Enable(ifen1), .IFID_Clear(ifclr1),
        .IDEX_Clear(idclr1), .EXMEM_Enable(exen1), .Mem_Error(err1),
        .Dbg_State(st1)
`ifdef HAZARD_PERF_EN
        , .Stall_Cycles(stall1), .Flush_Events(flush1)
`endif
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- checking / driver tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_check();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        ID_Rn = 4'd0; ID_Rm = 4'd0; ID_Rn_Used = 1'b0; ID_Rm_Used = 1'b0;
        EX_Load = 1'b0; EX_rf = 1'b0; EX_Rd = 4'd0;
        Branch_Taken = 1'b0; Mem_Req = 1'b0; Mem_Ready = 1'b0;
    endtask

    task automatic set_lu();
        EX_Load = 1'b1; EX_rf = 1'b1; EX_Rd = 4'd3; ID_Rn = 4'd3; ID_Rn_Used = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        CLR = 1'b0;
        idle_inputs();

        // Reset values
        repeat (2) @(posedge CLK);
        at_check();
        chk("rst_o0", o0, V_RST);
        chk("rst_o1", o1, V_RST);
        chk("rst_st0", st0, S_RUN);
        tick();
        CLR = 1'b1;
        at_check();
        chk("run_o0", o0, V_RUN);
        chk("run_o1", o1, V_RUN);
        tick();

        // Load-use
        set_lu();
        at_check(); chk("lu_rn", o0, V_LU);
        tick();
        ID_Rn_Used = 1'b0;
        at_check(); chk("lu_rn_unused", o0, V_RUN);
        tick();
        ID_Rm = 4'd3; ID_Rm_Used = 1'b1;
        at_check(); chk("lu_rm", o0, V_LU); chk("lu_rm_1", o1, V_LU);
        tick();
        EX_rf = 1'b0;
        at_check(); chk("lu_no_rf", o0, V_RUN);
        tick();
        idle_inputs();

        // Branch: 2 squash cycles on u_dut, 1 on u_dut1
        exp_q.push_back(V_BR);
        exp_q.push_back(V_BR);
        exp_q.push_back(V_RUN);
        Branch_Taken = 1'b1;
        at_check(); chk("br0_c0", o0, exp_q.pop_front()); chk("br1_c0", o1, V_BR);
        tick();
        Branch_Taken = 1'b0;
        at_check(); chk("br0_c1", o0, exp_q.pop_front()); chk("br0_st", st0, S_FL);
        chk("br1_c1", o1, V_RUN); chk("br1_st", st1, S_RUN);
        tick();
        at_check(); chk("br0_c2", o0, exp_q.pop_front()); chk("br0_st2", st0, S_RUN);
        tick();

        // Memory wait: Ready low 3 cycles, then high
        Mem_Req = 1'b1; Mem_Ready = 1'b0;
        at_check(); chk("mw_c0", o0, V_FRZ); chk("mw1_c0", o1, V_FRZ);
        tick();
        Mem_Req = 1'b0;
        at_check(); chk("mw_c1", o0, V_FRZ); chk("mw_st", st0, S_MW);
        tick();
        at_check(); chk("mw_c2", o0, V_FRZ);
        tick();
        Mem_Ready = 1'b1;
        at_check(); chk("mw_c3", o0, V_FRZ);
        tick();
        Mem_Ready = 1'b0;
        at_check(); chk("mw_resume", o0, V_RUN); chk("mw1_resume", o1, V_RUN);
        tick();

        // Priority: memory stall beats branch and load-use
        Mem_Req = 1'b1; Mem_Ready = 1'b0; Branch_Taken = 1'b1; set_lu();
        at_check(); chk("pri_c0", o0, V_FRZ); chk("pri1_c0", o1, V_FRZ);
        tick();
        Mem_Req = 1'b0; Mem_Ready = 1'b1;
        at_check(); chk("pri_c1", o0, V_FRZ); chk("pri_st", st0, S_MW);
        tick();
        Mem_Ready = 1'b0;
        at_check(); chk("pri_br", o0, V_BR); chk("pri1_br", o1, V_BR);
        tick();
        idle_inputs();
        at_check(); chk("pri_fl", o0, V_BR); chk("pri1_run", o1, V_RUN);
        tick();

        // Memory request during FLUSH drops the flush
        Branch_Taken = 1'b1;
        at_check(); chk("flm_c0", o0, V_BR);
        tick();
        Branch_Taken = 1'b0; Mem_Req = 1'b1;
        at_check(); chk("flm_c1", o0, V_BR); chk("flm1_c1", o1, V_FRZ);
        tick();
        Mem_Req = 1'b0;
        at_check(); chk("flm_st0", st0, S_MW); chk("flm_st1", st1, S_MW); chk("flm_c2", o0, V_FRZ);
        tick();
        Mem_Ready = 1'b1;
        at_check(); chk("flm_c3", o0, V_FRZ);
        tick();
        Mem_Ready = 1'b0;
        at_check(); chk("flm_resume", o0, V_RUN);
        tick();

        // Timeout: 15 MEMWAIT cycles then sticky error
        Mem_Req = 1'b1;
        at_check(); chk("to_c0", o0, V_FRZ);
        tick();
        Mem_Req = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            at_check(); chk("to_wait", o0, V_FRZ); chk("to_wait1", o1, V_FRZ);
            tick();
        end
        at_check(); chk("to_err", o0, V_RUNE); chk("to_err1", o1, V_RUNE);
        tick();
        Branch_Taken = 1'b1;
        at_check(); chk("to_sticky_br", o0, V_BRE);
        tick();
        Branch_Taken = 1'b0;
        at_check(); chk("to_sticky_fl", o0, V_BRE); chk("to_sticky1", o1, V_RUNE);
        tick();

        // Asynchronous reset in FLUSH with counter=1
        Branch_Taken = 1'b1;
        tick();
        Branch_Taken = 1'b0;
        #1;
        chk("ar_pre_st", st0, S_FL);
        CLR = 1'b0;
        #1;
        chk("ar_o0", o0, V_RST); chk("ar_o1", o1, V_RST); chk("ar_st0", st0, S_RUN);
        tick();
        CLR = 1'b1;
        at_check(); chk("ar_run0", o0, V_RUN); chk("ar_run1", o1, V_RUN);

`ifdef HAZARD_PERF_EN
        chk("perf_stall0_rst", stall0, 16'd0);
        chk("perf_flush0_rst", flush0, 16'd0);
        tick();
        set_lu();
        tick();
        idle_inputs();
        Mem_Req = 1'b1;
        tick();
        Mem_Req = 1'b0; Mem_Ready = 1'b1;
        tick();
        Mem_Ready = 1'b0; Branch_Taken = 1'b1;
        tick();
        Branch_Taken = 1'b0;
        tick();
        at_check();
        chk("perf_stall0", stall0, 16'd3);
        chk("perf_flush0", flush0, 16'd1);
        chk("perf_stall1", stall1, 16'd3);
        chk("perf_flush1", flush1, 16'd1);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
